// File: rtl/spi_reg_master_if.sv
// Request/response bundle between a register-access client and spi_reg_master.
// The master modport is the client side; slave is the spi_reg_master side.
interface spi_reg_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator issuing one 16-bit register read/write frame per request.
// Define SPI_REG_MASTER_MISO_SYNC_EN to add a 2-flop miso synchroniser (needs CLK_DIV >= 3).
module spi_reg_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic            clk,
  input  logic            rst,
  spi_reg_master_if.slave bus,
  output logic            spi_cs,
  output logic            spi_clk,
  output logic            spi_mosi,
  input  logic            spi_miso
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

  logic miso_in;

`ifdef SPI_REG_MASTER_MISO_SYNC_EN
  // Synchronised miso lags the pin by two clocks, so sample at the end of the high phase.
  localparam bit SAMPLE_LATE = 1'b1;
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], spi_miso};
  end

  assign miso_in = sync_q[1];
`else
  localparam bit SAMPLE_LATE = 1'b0;
  assign miso_in = spi_miso;
`endif

  logic [2:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    sclk_d      = sclk_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          tx_d    = {bus.req_write, bus.req_addr, bus.req_write ? bus.req_wdata : 8'h00};
          state_d = SETUP;
          div_d   = SETUP_LAST;
        end
      end
      SETUP: begin
        if (div_q == 8'd0) begin
          state_d = SHIFT;
          div_d   = DIV_LAST;
          bit_d   = 5'd0;
          sclk_d  = 1'b0;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      SHIFT: begin
        if (div_q != 8'd0) begin
          div_d = div_q - 8'd1;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          div_d  = DIV_LAST;
          if (!SAMPLE_LATE) rx_d = {rx_q[6:0], miso_in};
        end else begin
          sclk_d = 1'b0;
          bit_d  = bit_q + 5'd1;
          if (SAMPLE_LATE) rx_d = {rx_q[6:0], miso_in};
          if (bit_q == 5'd15) begin
            state_d = HOLD;
            div_d   = HOLD_LAST;
          end else begin
            div_d = DIV_LAST;
            tx_d  = {tx_q[14:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (div_q == 8'd0) begin
          state_d     = GAP;
          div_d       = GAP_LAST;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rx_q;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      GAP: begin
        if (div_q == 8'd0) state_d = IDLE;
        else               div_d   = div_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // Pins are registered from the next state so they never glitch.
    cs_d   = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
    mosi_d = (state_d == SETUP || state_d == SHIFT) ? tx_d[15] : 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign spi_cs        = cs_q;
  assign spi_clk       = sclk_q;
  assign spi_mosi      = mosi_q;
  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: two lanes (CLK_DIV=4 and a fast divider), each with a
// mode-0 slave model and a cycle-level expectation computed from frame arithmetic.
module tb_spi_reg_master;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 4;
`ifdef SPI_REG_MASTER_MISO_SYNC_EN
  localparam int FAST_DIV = 3;
`else
  localparam int FAST_DIV = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       req_valid = '0;
  logic [1:0]       req_write = '0;
  logic [1:0][6:0]  req_addr  = '0;
  logic [1:0][7:0]  req_wdata = '0;
  logic [1:0][15:0] miso_word = '0;
  logic [1:0]       req_ready, rsp_valid, busy, spi_cs, spi_clk, spi_mosi, spi_miso;
  logic [1:0][7:0]  rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_lane
    localparam int D = (g == 0) ? 4 : FAST_DIV;
    localparam int L = CS_SETUP + 32 * D + CS_HOLD;

    spi_reg_master_if bus ();
    assign bus.req_valid = req_valid[g];
    assign bus.req_write = req_write[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_rdata[g]  = bus.rsp_rdata;
    assign busy[g]       = bus.busy;

    spi_reg_master #(
      .CLK_DIV (D),
      .CS_SETUP(CS_SETUP),
      .CS_HOLD (CS_HOLD),
      .CS_GAP  (CS_GAP)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .spi_cs  (spi_cs[g]),
      .spi_clk (spi_clk[g]),
      .spi_mosi(spi_mosi[g]),
      .spi_miso(spi_miso[g])
    );

    // Mode-0 slave: shifts word_lat out MSB first, next bit after each sclk fall.
    logic [15:0] word_lat = '0, cap = '0, last_cap = '0;
    int falls = 0, rises = 0, cs_low = 0, last_cs_low = 0;
    int cyc = 0, last_rise_cyc = 0, last_period = 0, rsp_cnt = 0;
    logic prev_sclk = 1'b0, prev_cs = 1'b1;

    assign spi_miso[g] = (falls < 16) ? word_lat[4'(15 - falls)] : 1'b0;

    always @(negedge clk) begin : slave
      cyc++;
      if (spi_cs[g]) begin
        if (!prev_cs) begin
          last_cs_low = cs_low;
          if (rises == 16) last_cap = cap;
        end
        word_lat = miso_word[g];
        falls = 0;
        rises = 0;
        cs_low = 0;
      end else begin
        cs_low++;
        if (spi_clk[g] && !prev_sclk) begin
          rises++;
          cap = {cap[14:0], spi_mosi[g]};
          if (rises > 1) last_period = cyc - last_rise_cyc;
          last_rise_cyc = cyc;
        end
        if (!spi_clk[g] && prev_sclk) falls++;
      end
      if (rsp_valid[g]) rsp_cnt++;
      prev_sclk = spi_clk[g];
      prev_cs   = spi_cs[g];
    end

    // Model: k = cycles since acceptance; frame occupies k = 1..L+CS_GAP.
    bit          act = 1'b0;
    int          k = 0;
    logic [15:0] frame = '0;
    logic [7:0]  exp_byte = '0, rdata_exp = '0;

    always @(posedge clk) begin : model
      if (rst) begin
        act = 1'b0;
        rdata_exp = 8'h00;
      end else if (act) begin
        if (k == L + CS_GAP) begin
          act = 1'b0;
        end else begin
          k++;
          if (k == L + 1) rdata_exp = exp_byte;
        end
      end else if (req_valid[g]) begin
        act = 1'b1;
        k = 1;
        frame = {req_write[g], req_addr[g], req_write[g] ? req_wdata[g] : 8'h00};
        exp_byte = miso_word[g][7:0];
      end
    end

    always @(negedge clk) begin : compare
      logic e_cs, e_clk, e_mosi, e_ready, e_busy, e_rv;
      int m;
      if (rst) begin
        check($sformatf("lane%0d_ready_in_reset", g), 32'(req_ready[g]), 32'd0);
      end else begin
        e_cs = 1'b1; e_clk = 1'b0; e_mosi = 1'b0; e_ready = 1'b1; e_busy = 1'b0; e_rv = 1'b0;
        if (act) begin
          e_ready = 1'b0;
          e_busy  = 1'b1;
          e_cs    = !(k <= L);
          e_rv    = (k == L + 1);
          m = k - 1 - CS_SETUP;
          if (k <= CS_SETUP) begin
            e_mosi = frame[15];
          end else if (m < 32 * D) begin
            e_clk  = (m % (2 * D)) >= D;
            e_mosi = frame[15 - m / (2 * D)];
          end
        end
        check($sformatf("lane%0d_cs_clk_mosi_ready_busy_rv_rdata", g),
              32'({spi_cs[g], spi_clk[g], spi_mosi[g], req_ready[g], busy[g], rsp_valid[g], rsp_rdata[g]}),
              32'({e_cs, e_clk, e_mosi, e_ready, e_busy, e_rv, rdata_exp}));
      end
    end
  end

  task automatic do_req(input int g, input logic w, input logic [6:0] a,
                        input logic [7:0] d, input logic [15:0] word);
    bit ok;
    @(posedge clk); #1;
    req_write[g] = w;
    req_addr[g]  = a;
    req_wdata[g] = d;
    miso_word[g] = word;
    req_valid[g] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (req_ready[g]) begin ok = 1'b1; break; end
    end
    check("accept_within_budget", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (req_ready[g]) begin ok = 1'b1; break; end
    end
    check("idle_within_budget", 32'(ok), 32'd1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, r, lane;
    bit ok;
    logic p;

    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_cs", 32'(spi_cs), 32'h3);
    check("reset_clk_mosi", 32'({spi_clk, spi_mosi}), 32'h0);
    check("reset_ready_after", 32'(req_ready), 32'h3);
    check("reset_rdata", 32'(rsp_rdata), 32'h0);

    // Directed write: addr 0x03, data 0xA5.
    n = gen_lane[0].rsp_cnt;
    do_req(0, 1'b1, 7'h03, 8'hA5, 16'h0000);
    wait_idle(0);
    check("wr_mosi_frame", 32'(gen_lane[0].last_cap), 32'h83A5);
    check("wr_cs_low_cycles", 32'(gen_lane[0].last_cs_low), 32'd132);
    check("wr_rsp_pulses", 32'(gen_lane[0].rsp_cnt - n), 32'd1);

    // Directed read: addr 0x0C, slave returns 0x01.
    do_req(0, 1'b0, 7'h0C, 8'hFF, 16'h0001);
    wait_idle(0);
    check("rd_mosi_frame", 32'(gen_lane[0].last_cap), 32'h0C00);
    check("rd_rdata", 32'(rsp_rdata[0]), 32'h01);
    repeat (10) @(negedge clk);
    check("rd_rdata_held", 32'(rsp_rdata[0]), 32'h01);

    // Back-to-back with req_valid held: second accept CS_GAP cycles after cs rises.
    @(posedge clk); #1;
    req_write[0] = 1'b1; req_addr[0] = 7'h11; req_wdata[0] = 8'h22; req_valid[0] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (req_ready[0]) begin ok = 1'b1; break; end
    end
    check("b2b_first_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_addr[0] = 7'h12; req_wdata[0] = 8'h33;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (spi_cs[0]) begin ok = 1'b1; break; end
    end
    check("b2b_cs_rise", 32'(ok), 32'd1);
    n = 0;
    while (!req_ready[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("b2b_gap_cycles", 32'(n), 32'(CS_GAP));
    check("b2b_first_frame", 32'(gen_lane[0].last_cap), 32'h9122);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_idle(0);
    check("b2b_second_frame", 32'(gen_lane[0].last_cap), 32'h9233);

    // Reset at the 5th sclk rising edge aborts the frame with no response.
    n = gen_lane[0].rsp_cnt;
    do_req(0, 1'b1, 7'h55, 8'h0F, 16'h0000);
    r = 0; p = 1'b0;
    for (int t = 0; t < 3000 && r < 5; t++) begin
      @(negedge clk);
      if (spi_clk[0] && !p) r++;
      p = spi_clk[0];
    end
    check("abort_rise_count", 32'(r), 32'd5);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_pins_idle", 32'({spi_cs[0], spi_clk[0], spi_mosi[0]}), 32'h4);
    repeat (300) @(negedge clk);
    check("abort_no_rsp", 32'(gen_lane[0].rsp_cnt - n), 32'd0);
    do_req(0, 1'b0, 7'h0C, 8'h00, 16'hBEEF);
    wait_idle(0);
    check("after_abort_rdata", 32'(rsp_rdata[0]), 32'hEF);

    // Fast divider, miso alternating every bit.
    do_req(1, 1'b0, 7'h2A, 8'h00, 16'h5555);
    wait_idle(1);
    check("fast_rdata", 32'(rsp_rdata[1]), 32'h55);
    check("fast_sclk_period", 32'(gen_lane[1].last_period), 32'(2 * FAST_DIV));
    check("fast_cs_low_cycles", 32'(gen_lane[1].last_cs_low), 32'(CS_SETUP + 32 * FAST_DIV + CS_HOLD));

    // Randomised traffic on both lanes, sometimes re-requesting while busy.
    for (int i = 0; i < 24; i++) begin
      lane = int'($urandom_range(0, 1));
      do_req(lane, 1'($urandom), 7'($urandom), 8'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) != 0) wait_idle(lane);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    wait_idle(0);
    wait_idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_reg_master.md
Name: spi_reg_master

Overview:
- SPI mode-0 initiator that drives the chip's register-file SPI slave over the cs/sclk/mosi/miso pins.
- Accepts one register read or write request at a time on a valid/ready interface, serialises a 16-bit frame, and returns read data on a response strobe.
- Used as the on-board/FPGA-side controller, and as the bench driver for the top-level register map (12 RW + 1 RO registers).

Parameters:
- CLK_DIV, 4, system clocks per sclk half-period; legal range 2..255.
- CS_SETUP, 2, system clocks from cs falling to the first sclk rising edge.
- CS_HOLD, 2, system clocks from the last sclk falling edge to cs rising.
- CS_GAP, 4, minimum system clocks cs stays high between frames.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  7  register address.
- req_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle strobe at the end of every frame (reads and writes).
- rsp_rdata  out  8  byte captured during the data phase; valid while rsp_valid=1 and held until the next frame ends.
- busy  out  1  high from request acceptance until the end of the gap.
- spi_cs  out  1  chip select, active low.
- spi_clk  out  1  SPI clock, idle low.
- spi_mosi  out  1  master-out data.
- spi_miso  in  1  master-in data.

Behaviour:
- Reset values: spi_cs=1, spi_clk=0, spi_mosi=0, req_ready=0 during reset and 1 the cycle after, rsp_valid=0, rsp_rdata=0, busy=0; state=IDLE. Reset mid-frame aborts immediately: cs goes high and no response is issued.
- Frame format, MSB first, 16 bits:
  - bit15 = req_write.
  - bits14:8 = req_addr.
  - bits7:0 = req_wdata for writes, 0x00 for reads.
- Handshake:
  - A transfer is accepted when req_valid and req_ready are both high.
  - The request fields are latched into a 16-bit tx shift register on acceptance.
  - req_ready drops the next cycle.
- States and transitions:
  - IDLE: on accept, go to SETUP; spi_cs=0 from the next cycle.
  - SETUP: counts CS_SETUP cycles with spi_clk=0 and mosi=bit15, then goes to SHIFT.
  - SHIFT, for each of the 16 bits:
    - Low phase, CLK_DIV cycles: spi_clk=0, mosi holds the current bit.
    - High phase, CLK_DIV cycles: spi_clk=1.
    - miso is sampled into the rx shift register on the cycle spi_clk rises.
    - mosi updates to the next bit on the cycle spi_clk falls.
    - After the 16th falling edge, go to HOLD.
  - HOLD: CS_HOLD cycles with cs low and sclk low, then spi_cs=1 and go to GAP.
  - GAP:
    - rsp_valid pulses on the first GAP cycle, with rsp_rdata = rx bits 7:0 (the last 8 samples).
    - Counts CS_GAP cycles, then returns to IDLE.
- Counters:
  - An 8-bit divide counter reloads at each phase change.
  - A 5-bit bit counter runs 0..16.
  - There are no wrap cases beyond these terminal counts.
- Frame length: exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles of cs low.
- mosi returns to 0 in HOLD, GAP and IDLE.
- req_valid asserted outside IDLE is ignored and not queued. A request held across GAP is accepted on the first IDLE cycle.

Optional Feature:
- Macro: SPI_REG_MASTER_MISO_SYNC_EN.
- With the macro defined:
  - spi_miso passes through a two-flop synchroniser.
  - The sample point moves to the last cycle of each high phase.
  - CLK_DIV must be at least 3.
- Without the macro: spi_miso is sampled directly on the sclk-rising cycle.
- Frame timing and rsp_valid cycle are identical in both builds.

Test Plan:
- Write, addr 0x03, data 0xA5, CLK_DIV=4: mosi bits across 16 rising edges = 1000_0011_1010_0101; cs low for exactly 2+128+2 = 132 cycles; one rsp_valid pulse.
- Read, addr 0x0C, with the slave model returning 0x01 in the data phase: mosi = 0000_1100_0000_0000; rsp_rdata = 0x01 on the rsp_valid cycle and held afterwards.
- req_valid held high continuously for two writes: second acceptance exactly CS_GAP cycles after cs rises; cs high at least 4 cycles between frames; req_ready low throughout each frame.
- rst asserted at the 5th sclk rising edge of a frame: next cycle spi_cs=1, spi_clk=0, spi_mosi=0; no rsp_valid; the following request completes normally.
- CLK_DIV=2, miso toggling every bit (0x55 in the data byte): rsp_rdata = 0x55; sclk period = 4 clocks; repeat the build with SPI_REG_MASTER_MISO_SYNC_EN and CLK_DIV=3, expecting the same data.
